// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use and branch-operand stalls, taken-branch/jump
// flushes, data-memory freeze, and saturating stall/flush performance counters.
module hazard_detection_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_write_reg,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_write_reg,
    input  logic             dmem_busy,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic rs_match_ex;
    logic rt_match_ex;
    logic rs_match_mem;
    logic rt_match_mem;
    logic src_ex;
    logic src_mem;
    logic load_use;
    logic br_alu;
    logic br_load_ex;
    logic br_load_mem;
    logic haz;
    logic redirect;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    always_comb begin
        rs_match_ex  = (id_rs == id_ex_write_reg)  && (id_rs != 5'd0);
        rt_match_ex  = (id_rt == id_ex_write_reg)  && (id_rt != 5'd0);
        rs_match_mem = (id_rs == ex_mem_write_reg) && (id_rs != 5'd0);
        rt_match_mem = (id_rt == ex_mem_write_reg) && (id_rt != 5'd0);
        src_ex       = rs_match_ex  || (id_uses_rt && rt_match_ex);
        src_mem      = rs_match_mem || (id_uses_rt && rt_match_mem);
    end

    always_comb begin
        load_use    = id_ex_mem_read && src_ex;
        br_alu      = id_is_branch && id_ex_reg_write && !id_ex_mem_read && src_ex;
        br_load_ex  = id_is_branch && id_ex_mem_read && src_ex;
        br_load_mem = id_is_branch && ex_mem_mem_read && src_mem;
        haz         = load_use || br_alu || br_load_ex || br_load_mem;
        redirect    = id_jump || (id_is_branch && id_branch_taken);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A freeze holds the FSM; otherwise BR_WAIT supplies the second bubble of a
    // load feeding a branch and then returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (br_load_ex && !dmem_busy) begin
                    state_next = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (!dmem_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Priority is freeze over stall over flush; a held ID/EX must not be bubbled.
    always_comb begin
        freeze      = dmem_busy;
        stall       = 1'b0;
        if (!dmem_busy) begin
            case (state)
                IDLE:    stall = haz;
                BR_WAIT: stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
        pc_write    = !dmem_busy && !stall;
        if_id_write = !dmem_busy && !stall;
        if_id_flush = !dmem_busy && !stall && redirect;
    end

    // Counters saturate at all-ones; stall and flush are already 0 during freeze.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (if_id_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Generates the pipeline hold/bubble controls consumed by the ID-stage control-bubble mux and by the PC and IF/ID registers. Detects load-use and branch-operand hazards, tracks the two-cycle load-to-branch case with a small FSM, issues IF/ID flushes for taken branches and jumps, and freezes the whole pipeline while data memory is busy. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  the ID instruction reads rt as a source (R-type, beq, sw).
- `id_is_branch`  in  1  the ID instruction is a branch resolved in ID.
- `id_branch_taken`  in  1  the ID-stage branch comparator result; valid only when `id_is_branch` is 1.
- `id_jump`  in  1  the ID instruction is a jump.
- `id_ex_mem_read`  in  1  the instruction in EX is a load.
- `id_ex_reg_write`  in  1  the instruction in EX writes a register.
- `id_ex_write_reg`  in  5  destination register of the instruction in EX, after RegDst selection.
- `ex_mem_mem_read`  in  1  the instruction in MEM is a load.
- `ex_mem_write_reg`  in  5  destination register of the instruction in MEM.
- `dmem_busy`  in  1  data memory wait state.
- `stall`  out  1  to the control-bubble mux; 1 zeroes the control signals entering ID/EX.
- `pc_write`  out  1  PC load enable.
- `if_id_write`  out  1  IF/ID load enable.
- `if_id_flush`  out  1  clears IF/ID to a NOP at the next edge.
- `freeze`  out  1  holds ID/EX, EX/MEM and MEM/WB.
- `stall_count`  out  CNT_W  number of cycles with `stall` at 1; saturating.
- `flush_count`  out  CNT_W  number of cycles with `if_id_flush` at 1; saturating.

## Operation
- Match definitions:
  - `m_ex(r)` = (r == `id_ex_write_reg`) and (r != 0).
  - `m_mem(r)` = (r == `ex_mem_write_reg`) and (r != 0).
  - `src(f)` = f(`id_rs`) or (`id_uses_rt` and f(`id_rt`)).
- `load_use` = `id_ex_mem_read` and `src(m_ex)`.
- `br_alu` = `id_is_branch` and `id_ex_reg_write` and not `id_ex_mem_read` and `src(m_ex)`. This case needs one bubble.
- `br_load_ex` = `id_is_branch` and `id_ex_mem_read` and `src(m_ex)`. This case needs two bubbles.
- `br_load_mem` = `id_is_branch` and `ex_mem_mem_read` and `src(m_mem)`. This case needs one bubble.
- FSM states:
  - IDLE (reset state):
    - `haz` = `load_use` or `br_alu` or `br_load_ex` or `br_load_mem`.
    - `br_load_ex` and not `dmem_busy` → BR_WAIT.
    - Otherwise stay in IDLE.
  - BR_WAIT: forces `stall` to 1 regardless of the hazard inputs.
    - Not `dmem_busy` → IDLE.
    - `dmem_busy` → stay in BR_WAIT.
- Output priority is freeze > stall > flush:
  - `freeze` = `dmem_busy`.
  - `stall` = not `dmem_busy` and (BR_WAIT or (IDLE and `haz`)).
  - `pc_write` = `if_id_write` = not `dmem_busy` and not `stall`.
  - `if_id_flush` = not `dmem_busy` and not `stall` and (`id_jump` or (`id_is_branch` and `id_branch_taken`)).
- A branch never flushes while it is stalled; it flushes in its first non-stalled cycle.
- During freeze, FSM state and both counters hold. `stall` is 0 because ID/EX is held, not bubbled.
- Counters:
  - Each counter increments by 1 per cycle when its output is 1.
  - Each counter saturates at all-ones; no wrap-around.

## Timing
- Control outputs (`stall`, `pc_write`, `if_id_write`, `if_id_flush`, `freeze`) are combinational from the current inputs and state; they have zero latency relative to the hazard.
- FSM state and counters update on the rising edge of `clk`.
- Reset (`rst_n` = 0 at an edge), including in the middle of BR_WAIT:
  - Next state is IDLE; `stall_count` and `flush_count` are 0.
  - The combinational outputs follow the inputs immediately after reset. With idle inputs: `stall` 0, `pc_write` 1, `if_id_write` 1, `if_id_flush` 0, `freeze` 0.
- Load followed by a dependent branch:
  - Cycle n: IDLE, `br_load_ex`, `stall` 1.
  - Cycle n+1: BR_WAIT, `stall` 1.
  - Cycle n+2: IDLE; the load has reached WB and the branch proceeds.
- Register 0 never causes a hazard.

## Test plan
- Load-use: `id_ex_mem_read`=1, `id_ex_write_reg`=8, `id_rs`=8 → `stall`=1, `pc_write`=0, `if_id_write`=0 for exactly 1 cycle; `stall_count` goes 0→1.
- Load then dependent beq: `id_is_branch`=1, `id_rt`=9, `id_uses_rt`=1, EX load to reg 9 in cycle n, bubble in cycle n+1 → `stall`=1 in cycles n and n+1, 0 in n+2; `stall_count`=2.
- Taken branch, no hazard: `id_is_branch`=1, `id_branch_taken`=1 → `if_id_flush`=1, `stall`=0, `pc_write`=1. The same case with `br_alu` true gives `if_id_flush`=0 in the stall cycle and `if_id_flush`=1 in the following cycle.
- Freeze in BR_WAIT: enter BR_WAIT, hold `dmem_busy`=1 for 3 cycles → `freeze`=1, `stall`=0, `pc_write`=0, counters constant, state stays BR_WAIT. After `dmem_busy` drops: 1 `stall` cycle, then IDLE.
- Register 0: `id_ex_mem_read`=1, `id_ex_write_reg`=0, `id_rs`=0 → `stall`=0.
- Reset in BR_WAIT and counter saturation:
  - Pull `rst_n`=0 for 1 edge while in BR_WAIT → next cycle is IDLE, `stall`=0, counters 0.
  - With `CNT_W`=4, apply 20 stall cycles → `stall_count` holds at 15.
